// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 decode slice: instruction codes,
// register ids, datapath width and the D pipeline-register layout.
package y86_pkg;

  localparam int XLEN  = 64;
  localparam int NREGS = 15;

  typedef logic [3:0]      reg_id_t;
  typedef logic [3:0]      icode_t;
  typedef logic [XLEN-1:0] word_t;

  // Instruction codes
  localparam icode_t I_HALT   = 4'h0;
  localparam icode_t I_NOP    = 4'h1;
  localparam icode_t I_RRMOVQ = 4'h2;
  localparam icode_t I_IRMOVQ = 4'h3;
  localparam icode_t I_RMMOVQ = 4'h4;
  localparam icode_t I_MRMOVQ = 4'h5;
  localparam icode_t I_OPQ    = 4'h6;
  localparam icode_t I_JXX    = 4'h7;
  localparam icode_t I_CALL   = 4'h8;
  localparam icode_t I_RET    = 4'h9;
  localparam icode_t I_PUSHQ  = 4'hA;
  localparam icode_t I_POPQ   = 4'hB;

  // Register ids
  localparam reg_id_t RNONE = 4'hF;
  localparam reg_id_t RRSP  = 4'h4;

  // Contents of the D pipeline register
  typedef struct packed {
    icode_t     icode;
    logic [3:0] ifun;
    reg_id_t    ra;
    reg_id_t    rb;
    word_t      valc;
    word_t      valp;
    logic       valid;
  } d_reg_t;

  // Value loaded on reset and on a bubble: a valid NOP with no operands
  localparam d_reg_t D_RESET = '{
    icode: I_NOP,
    ifun:  4'h0,
    ra:    RNONE,
    rb:    RNONE,
    valc:  '0,
    valp:  '0,
    valid: 1'b1
  };

endpackage

// File: rtl/decode_stage_if.sv
// Bundle of the signals around the decode stage: fetch inputs, pipeline
// control, write-back port and the outputs towards execute.
// master = the surrounding pipeline / testbench, slave = decode_stage.
interface decode_stage_if;
  import y86_pkg::*;

  // From fetch
  icode_t     f_icode;
  logic [3:0] f_ifun;
  reg_id_t    f_rA;
  reg_id_t    f_rB;
  word_t      f_valC;
  word_t      f_valP;
  logic       f_instr_valid;

  // Pipeline control
  logic       D_stall;
  logic       D_bubble;

  // Write-back from W stage
  reg_id_t    W_dstE;
  word_t      W_valE;
  reg_id_t    W_dstM;
  word_t      W_valM;

  // To execute / hazard unit
  icode_t     d_icode;
  logic [3:0] d_ifun;
  word_t      d_valC;
  word_t      d_valA;
  word_t      d_valB;
  reg_id_t    d_srcA;
  reg_id_t    d_srcB;
  reg_id_t    d_dstE;
  reg_id_t    d_dstM;
  logic       d_instr_valid;

  modport master (
    output f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_instr_valid,
    output D_stall, D_bubble,
    output W_dstE, W_valE, W_dstM, W_valM,
    input  d_icode, d_ifun, d_valC, d_valA, d_valB,
    input  d_srcA, d_srcB, d_dstE, d_dstM, d_instr_valid
  );

  modport slave (
    input  f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_instr_valid,
    input  D_stall, D_bubble,
    input  W_dstE, W_valE, W_dstM, W_valM,
    output d_icode, d_ifun, d_valC, d_valA, d_valB,
    output d_srcA, d_srcB, d_dstE, d_dstM, d_instr_valid
  );

endinterface

// File: rtl/y86_regfile.sv
// Y86-64 register file: 15 x 64-bit, two combinational read ports, two
// write ports (E and M) with M taking priority on a shared destination,
// asynchronous clear. Id RNONE reads as zero and never writes.
// Optional: define WB_BYPASS_EN to forward same-cycle write data to the
// read ports (M over E); otherwise reads return the stored value.
module y86_regfile
  import y86_pkg::*;
#(
  parameter int NR = NREGS
) (
  input  logic    clk,
  input  logic    rst_n,
  input  reg_id_t rd_a_id_i,
  input  reg_id_t rd_b_id_i,
  output word_t   rd_a_o,
  output word_t   rd_b_o,
  input  reg_id_t wr_e_id_i,
  input  word_t   wr_e_data_i,
  input  reg_id_t wr_m_id_i,
  input  word_t   wr_m_data_i
);

  word_t regs_q [NR];

  // Register array write: async clear, then E write followed by M write
  // NOTE: this array is cleared on reset on purpose -- architectural state
  // must read zero after reset, so it is flops, not an inferred RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      // NOTE: with non-blocking assignments the last one to the same
      // element wins, so placing the M write second gives it priority.
      if (wr_e_id_i != RNONE) regs_q[wr_e_id_i] <= wr_e_data_i;
      if (wr_m_id_i != RNONE) regs_q[wr_m_id_i] <= wr_m_data_i;
    end
  end

  // Read port A: stored value (optionally bypassed), RNONE reads zero
  always_comb begin
    // NOTE: assign a default first so every path drives the output and
    // no latch is inferred.
    rd_a_o = '0;
    if (rd_a_id_i != RNONE) begin
      rd_a_o = regs_q[rd_a_id_i];
`ifdef WB_BYPASS_EN
      if (rd_a_id_i == wr_e_id_i) rd_a_o = wr_e_data_i;
      if (rd_a_id_i == wr_m_id_i) rd_a_o = wr_m_data_i;
`endif
    end
  end

  // Read port B: same rules as port A
  always_comb begin
    rd_b_o = '0;
    if (rd_b_id_i != RNONE) begin
      rd_b_o = regs_q[rd_b_id_i];
`ifdef WB_BYPASS_EN
      if (rd_b_id_i == wr_e_id_i) rd_b_o = wr_e_data_i;
      if (rd_b_id_i == wr_m_id_i) rd_b_o = wr_m_data_i;
`endif
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Y86-64 decode stage: D pipeline register (stall > bubble > load),
// source/destination id derivation, valA select and the register file.
// Optional: WB_BYPASS_EN (consumed by y86_regfile) makes write-back data
// visible to decode in the same cycle.
module decode_stage
  import y86_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  decode_stage_if.slave  bus
);

  d_reg_t  d_q;
  d_reg_t  d_d;

  reg_id_t src_a;
  reg_id_t src_b;
  reg_id_t dst_e;
  reg_id_t dst_m;
  word_t   rd_a;
  word_t   rd_b;

  // D register next state: hold on stall, NOP on bubble, else load fetch
  always_comb begin
    d_d = d_q;
    if (bus.D_stall) begin
      d_d = d_q;
    end else if (bus.D_bubble) begin
      d_d = D_RESET;
    end else begin
      d_d.icode = bus.f_icode;
      d_d.ifun  = bus.f_ifun;
      d_d.ra    = bus.f_rA;
      d_d.rb    = bus.f_rB;
      d_d.valc  = bus.f_valC;
      d_d.valp  = bus.f_valP;
      d_d.valid = bus.f_instr_valid;
    end
  end

  // D register state: async reset to the NOP value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= D_RESET;
    end else begin
      d_q <= d_d;
    end
  end

  // Source ids; unlisted (incl. invalid) icodes use no register
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    case (d_q.icode)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: src_a = d_q.ra;
      I_RET, I_POPQ:                      src_a = RRSP;
      default:                            src_a = RNONE;
    endcase
    case (d_q.icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:          src_b = d_q.rb;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     src_b = RRSP;
      default:                            src_b = RNONE;
    endcase
  end

  // Destination ids; unlisted (incl. invalid) icodes write nothing
  always_comb begin
    dst_e = RNONE;
    dst_m = RNONE;
    case (d_q.icode)
      I_RRMOVQ, I_IRMOVQ, I_OPQ:          dst_e = d_q.rb;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     dst_e = RRSP;
      default:                            dst_e = RNONE;
    endcase
    case (d_q.icode)
      I_MRMOVQ, I_POPQ:                   dst_m = d_q.ra;
      default:                            dst_m = RNONE;
    endcase
  end

  y86_regfile #(
    .NR (NREGS)
  ) u_regfile (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_a_id_i   (src_a),
    .rd_b_id_i   (src_b),
    .rd_a_o      (rd_a),
    .rd_b_o      (rd_b),
    .wr_e_id_i   (bus.W_dstE),
    .wr_e_data_i (bus.W_valE),
    .wr_m_id_i   (bus.W_dstM),
    .wr_m_data_i (bus.W_valM)
  );

  // Outputs to execute: call and jump carry valP in valA
  always_comb begin
    bus.d_icode       = d_q.icode;
    bus.d_ifun        = d_q.ifun;
    bus.d_valC        = d_q.valc;
    bus.d_valA        = (d_q.icode == I_JXX || d_q.icode == I_CALL) ? d_q.valp : rd_a;
    bus.d_valB        = rd_b;
    bus.d_srcA        = src_a;
    bus.d_srcB        = src_b;
    bus.d_dstE        = dst_e;
    bus.d_dstM        = dst_m;
    bus.d_instr_valid = d_q.valid;
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus computes expected outputs
// from a behavioural model and queues them; a monitor on the falling edge
// pops and compares against the DUT.
module tb_decode_stage;
  import y86_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  decode_stage_if bus ();

  decode_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic        valid, stall, bubble;
    logic [3:0]  wde;
    logic [63:0] wve;
    logic [3:0]  wdm;
    logic [63:0] wvm;
  } stim_t;

  typedef struct {
    logic [3:0]  icode, ifun, srca, srcb, dste, dstm;
    logic [63:0] valc, vala, valb;
    logic        valid;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors     = 0;
  int          miscompares = 0;

  // Behavioural model state
  logic [63:0] m_regs [16];
  stim_t       m_d;
  stim_t       cur;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.icode = 4'h1;
    s.ra    = 4'hF;
    s.rb    = 4'hF;
    s.valid = 1'b1;
    s.wde   = 4'hF;
    s.wdm   = 4'hF;
    return s;
  endfunction

  function automatic stim_t mk(input logic [3:0] ic, input logic [3:0] fn,
                               input logic [3:0] ra, input logic [3:0] rb,
                               input logic [63:0] vc, input logic [63:0] vp);
    stim_t s;
    s = idle();
    s.icode = ic; s.ifun = fn; s.ra = ra; s.rb = rb; s.valc = vc; s.valp = vp;
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_d = idle();
  endtask

  // Effect of a rising edge given the inputs applied during the cycle
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
      if (cur.wde != 4'hF) m_regs[cur.wde] = cur.wve;
      if (cur.wdm != 4'hF) m_regs[cur.wdm] = cur.wvm;
      if (cur.stall)       m_d = m_d;
      else if (cur.bubble) m_d = idle();
      else                 m_d = cur;
    end
  endtask

  function automatic logic [63:0] rd(input logic [3:0] id);
    if (id == 4'hF) return 64'h0;
`ifdef WB_BYPASS_EN
    if (id == cur.wdm) return cur.wvm;
    if (id == cur.wde) return cur.wve;
`endif
    return m_regs[id];
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    logic [3:0] ic;
    ic = m_d.icode;
    e.icode = ic;
    e.ifun  = m_d.ifun;
    e.valc  = m_d.valc;
    e.valid = m_d.valid;
    e.srca  = (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) ? m_d.ra :
              (ic inside {4'h9, 4'hB})             ? 4'h4   : 4'hF;
    e.srcb  = (ic inside {4'h4, 4'h5, 4'h6})       ? m_d.rb :
              (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4   : 4'hF;
    e.dste  = (ic inside {4'h2, 4'h3, 4'h6})       ? m_d.rb :
              (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4   : 4'hF;
    e.dstm  = (ic inside {4'h5, 4'hB})             ? m_d.ra : 4'hF;
    e.vala  = (ic == 4'h7 || ic == 4'h8) ? m_d.valp : rd(e.srca);
    e.valb  = rd(e.srcb);
    return e;
  endfunction

  task automatic apply(input stim_t s);
    cur               = s;
    bus.f_icode       = s.icode;
    bus.f_ifun        = s.ifun;
    bus.f_rA          = s.ra;
    bus.f_rB          = s.rb;
    bus.f_valC        = s.valc;
    bus.f_valP        = s.valp;
    bus.f_instr_valid = s.valid;
    bus.D_stall       = s.stall;
    bus.D_bubble      = s.bubble;
    bus.W_dstE        = s.wde;
    bus.W_valE        = s.wve;
    bus.W_dstM        = s.wdm;
    bus.W_valM        = s.wvm;
  endtask

  // One cycle: account for the edge, set reset level mid-cycle, drive new
  // inputs and queue what the DUT must show before the next edge.
  task automatic step(input stim_t s, input logic rst_val);
    @(posedge clk);
    #1;
    model_edge();
    rst_n = rst_val;
    if (!rst_val) begin
      model_reset();
      s.wde = 4'hF;
      s.wdm = 4'hF;
    end
    apply(s);
    exp_q.push_back(expect_now());
  endtask

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp_v, inout bit bad);
    if (act !== exp_v) begin
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp_v);
      bad = 1'b1;
    end
  endtask

  // Monitor: compare DUT outputs with the oldest queued expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    bit   bad;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      bad = 1'b0;
      check("d_icode", 64'(bus.d_icode), 64'(e.icode), bad);
      check("d_ifun",  64'(bus.d_ifun),  64'(e.ifun),  bad);
      check("d_valC",  bus.d_valC,       e.valc,       bad);
      check("d_valA",  bus.d_valA,       e.vala,       bad);
      check("d_valB",  bus.d_valB,       e.valb,       bad);
      check("d_srcA",  64'(bus.d_srcA),  64'(e.srca),  bad);
      check("d_srcB",  64'(bus.d_srcB),  64'(e.srcb),  bad);
      check("d_dstE",  64'(bus.d_dstE),  64'(e.dste),  bad);
      check("d_dstM",  64'(bus.d_dstM),  64'(e.dstm),  bad);
      check("d_instr_valid", 64'(bus.d_instr_valid), 64'(e.valid), bad);
      vectors++;
      if (bad) miscompares++;
    end
  end

  function automatic logic [3:0] rand_id();
    return ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 14));
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.icode  = 4'($urandom_range(0, 15));
    s.ifun   = 4'($urandom_range(0, 15));
    s.ra     = rand_id();
    s.rb     = rand_id();
    s.valc   = {$urandom, $urandom};
    s.valp   = {$urandom, $urandom};
    s.valid  = 1'($urandom_range(0, 1));
    s.stall  = ($urandom_range(0, 9) == 0);
    s.bubble = ($urandom_range(0, 9) == 0);
    s.wde    = ($urandom_range(0, 2) == 0) ? 4'hF : rand_id();
    s.wve    = {$urandom, $urandom};
    s.wdm    = ($urandom_range(0, 2) == 0) ? 4'hF : rand_id();
    s.wvm    = {$urandom, $urandom};
    return s;
  endfunction

  // Watchdog: the run must never hang
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    stim_t s;
    rst_n = 1'b0;
    model_reset();
    apply(idle());

    // Power-on reset, then release
    step(idle(), 1'b0);
    step(idle(), 1'b1);

    // irmovq $64, %rdx ; write-back of rdx ; OPq reading rdx
    step(mk(4'h3, 4'h0, 4'hF, 4'h2, 64'd64, 64'h0A), 1'b1);
    s = mk(4'h6, 4'h0, 4'h2, 4'h1, 64'h0, 64'h0C);
    s.wde = 4'h2; s.wve = 64'd64;
    step(s, 1'b1);
    step(idle(), 1'b1);

    // Stall holds, bubble inserts NOP, both together holds
    step(mk(4'h2, 4'h0, 4'h3, 4'h5, 64'h0, 64'h2), 1'b1);
    s = mk(4'h5, 4'h0, 4'h6, 4'h7, 64'h99, 64'h3); s.stall = 1'b1;
    step(s, 1'b1);
    s = mk(4'h5, 4'h0, 4'h6, 4'h7, 64'h99, 64'h3); s.bubble = 1'b1;
    step(s, 1'b1);
    step(mk(4'h6, 4'h1, 4'h1, 4'h2, 64'h0, 64'h4), 1'b1);
    s = mk(4'hA, 4'h0, 4'h3, 4'hF, 64'h0, 64'h5); s.stall = 1'b1; s.bubble = 1'b1;
    step(s, 1'b1);

    // popq %rsp: E and M both target rsp, M wins; then read rsp
    s = mk(4'h6, 4'h0, 4'h4, 4'h4, 64'h0, 64'h6);
    s.wde = 4'h4; s.wve = 64'h108; s.wdm = 4'h4; s.wvm = 64'h55;
    step(s, 1'b1);
    step(idle(), 1'b1);

    // call valP=0x20, then jump
    step(mk(4'h8, 4'h0, 4'hF, 4'hF, 64'h40, 64'h20), 1'b1);
    step(mk(4'h7, 4'h3, 4'hF, 4'hF, 64'h80, 64'h33), 1'b1);
    step(idle(), 1'b1);

    // Invalid icodes pass data through with no register ids
    step(mk(4'hC, 4'h5, 4'h1, 4'h2, 64'hDEAD, 64'hBEEF), 1'b1);
    step(mk(4'hF, 4'hF, 4'h3, 4'h4, 64'h1234, 64'h5678), 1'b1);

    // Same-cycle write of a register decode is reading
    step(mk(4'h6, 4'h0, 4'h1, 4'h2, 64'h0, 64'h7), 1'b1);
    s = idle(); s.stall = 1'b1; s.wde = 4'h1; s.wve = 64'h7;
    step(s, 1'b1);
    s = idle(); s.stall = 1'b1;
    step(s, 1'b1);

    // Write rbx, reset mid-run, then read rbx back as zero
    s = mk(4'h6, 4'h0, 4'h3, 4'h3, 64'h0, 64'h8); s.wde = 4'h3; s.wve = 64'hABCD;
    step(s, 1'b1);
    step(idle(), 1'b1);
    step(idle(), 1'b0);
    step(mk(4'h6, 4'h0, 4'h3, 4'h3, 64'h0, 64'h9), 1'b1);
    step(idle(), 1'b1);

    // Randomized traffic with occasional mid-run resets
    for (int i = 0; i < 600; i++) begin
      step(rand_stim(), ($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1);
    end

    // Drain the scoreboard
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      miscompares++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
